// File: rtl/ballot_controller.sv
// Voter-session sequencer: arm, qualify one stable candidate press, cast a
// one-hot increment, then lock out until the buttons are released.
module ballot_controller #(
  parameter int NUM_CAND       = 4,
  parameter int HOLD_CYCLES    = 4,
  parameter int LOCKOUT_CYCLES = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                ballot_enable,
  input  logic [NUM_CAND-1:0] cand_button,
  output logic [NUM_CAND-1:0] vote_inc,
  output logic                valid_vote_casted,
  output logic                ballot_ready,
  output logic                multi_press_err,
  output logic                timeout,
  output logic [15:0]         votes_total
);

  localparam int CNT_MAX_A = (HOLD_CYCLES > LOCKOUT_CYCLES) ? HOLD_CYCLES : LOCKOUT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCKOUT_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_QUALIFY = 3'd2,
    S_CAST    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CAND-1:0] sel_q, sel_d;
  logic [NUM_CAND-1:0] vote_inc_q, vote_inc_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic                multi_q, multi_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         votes_total_q, votes_total_d;

  logic no_press;
  logic one_press;

  assign no_press  = (cand_button == '0);
  // A non-zero vector with no second bit set is exactly one-hot.
  assign one_press = !no_press &&
                     ((cand_button & (cand_button - NUM_CAND'(1))) == '0);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    multi_d       = 1'b0;
    timeout_d     = 1'b0;
    votes_total_d = votes_total_q;

    case (state_q)
      S_IDLE: begin
        if (!mode && ballot_enable) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (mode) begin
          state_d = S_IDLE;
        end else if (no_press) begin
          if (cnt_q == TIMEOUT_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (one_press) begin
          sel_d   = cand_button;
          state_d = S_QUALIFY;
        end else begin
          multi_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_QUALIFY: begin
        if (mode) begin
          state_d = S_IDLE;
        end else if (cand_button != sel_q) begin
          state_d = S_ARMED;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_CAST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAST: begin
        state_d = S_LOCKOUT;
      end
      S_LOCKOUT: begin
        if (cnt_q != LOCKOUT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else if (no_press) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The press that moves ARMED to QUALIFY is already the first qualifying sample.
    if (state_d != state_q) begin
      cnt_d = (state_d == S_QUALIFY) ? CNT_W'(1) : '0;
    end

    if (state_d == S_CAST && votes_total_q != 16'hFFFF) begin
      votes_total_d = votes_total_q + 16'd1;
    end

    vote_inc_d = (state_d == S_CAST) ? sel_d : '0;
    valid_d    = (state_d == S_CAST);
    ready_d    = (state_d == S_ARMED) || (state_d == S_QUALIFY);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      sel_q         <= '0;
      vote_inc_q    <= '0;
      valid_q       <= 1'b0;
      ready_q       <= 1'b0;
      multi_q       <= 1'b0;
      timeout_q     <= 1'b0;
      votes_total_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      vote_inc_q    <= vote_inc_d;
      valid_q       <= valid_d;
      ready_q       <= ready_d;
      multi_q       <= multi_d;
      timeout_q     <= timeout_d;
      votes_total_q <= votes_total_d;
    end
  end

  assign vote_inc          = vote_inc_q;
  assign valid_vote_casted = valid_q;
  assign ballot_ready      = ready_q;
  assign multi_press_err   = multi_q;
  assign timeout           = timeout_q;
  assign votes_total       = votes_total_q;

endmodule

// File: tb/tb_ballot_controller.sv
// Directed and randomized voter sessions for ballot_controller, scored against
// per-candidate vote tallies derived from the session rules.
module tb_ballot_controller;

  localparam int NC   = 4;
  localparam int HOLD = 4;
  localparam int LOCK = 10;
  localparam int TO   = 20;

  logic          clock = 1'b0;
  logic          reset;
  logic          mode;
  logic          ballot_enable;
  logic [NC-1:0] cand_button;
  logic [NC-1:0] vote_inc;
  logic          valid_vote_casted;
  logic          ballot_ready;
  logic          multi_press_err;
  logic          timeout;
  logic [15:0]   votes_total;

  ballot_controller #(
    .NUM_CAND      (NC),
    .HOLD_CYCLES   (HOLD),
    .LOCKOUT_CYCLES(LOCK),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .mode             (mode),
    .ballot_enable    (ballot_enable),
    .cand_button      (cand_button),
    .vote_inc         (vote_inc),
    .valid_vote_casted(valid_vote_casted),
    .ballot_ready     (ballot_ready),
    .multi_press_err  (multi_press_err),
    .timeout          (timeout),
    .votes_total      (votes_total)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Observed event tallies, sampled on the inactive edge.
  int inc_seen[NC];
  int mp_seen        = 0;
  int to_seen        = 0;
  int multihot_seen  = 0;
  int incoherent_seen = 0;

  // Reference tallies from the session rules.
  int exp_votes[NC];
  int exp_total = 0;
  int exp_mp    = 0;
  int exp_to    = 0;

  initial begin
    for (int i = 0; i < NC; i++) begin
      inc_seen[i]  = 0;
      exp_votes[i] = 0;
    end
  end

  always @(negedge clock) begin
    for (int i = 0; i < NC; i++) if (vote_inc[i]) inc_seen[i]++;
    if ($countones(vote_inc) > 1) multihot_seen++;
    if (valid_vote_casted != (vote_inc != '0)) incoherent_seen++;
    if (multi_press_err) mp_seen++;
    if (timeout) to_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic logic [NC-1:0] onehot(input int c);
    logic [NC-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic arm();
    mode          = 1'b0;
    ballot_enable = 1'b1;
    tick(1);
    ballot_enable = 1'b0;
    check("arm_ready", 32'(ballot_ready), 1);
  endtask

  task automatic hold(input logic [NC-1:0] pat, input int n);
    cand_button = pat;
    tick(n);
    cand_button = '0;
  endtask

  task automatic model_vote(input int c);
    exp_votes[c]++;
    if (exp_total < 65535) exp_total++;
  endtask

  task automatic scoreboard(input string tag);
    for (int i = 0; i < NC; i++)
      check($sformatf("%s_cand%0d", tag, i), 32'(inc_seen[i]), 32'(exp_votes[i]));
    check({tag, "_total"}, 32'(votes_total), 32'(exp_total));
    check({tag, "_multi_err"}, 32'(mp_seen), 32'(exp_mp));
    check({tag, "_timeouts"}, 32'(to_seen), 32'(exp_to));
    check({tag, "_multihot"}, 32'(multihot_seen), 0);
    check({tag, "_valid_sync"}, 32'(incoherent_seen), 0);
  endtask

  initial begin
    int            c;
    int            n;
    int            k;
    logic [NC-1:0] pat;
    logic          ready_seen;

    reset         = 1'b1;
    mode          = 1'b0;
    ballot_enable = 1'b0;
    cand_button   = '0;
    tick(3);
    check("rst_vote_inc", 32'(vote_inc), 0);
    check("rst_valid", 32'(valid_vote_casted), 0);
    check("rst_ready", 32'(ballot_ready), 0);
    check("rst_multi", 32'(multi_press_err), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_total", 32'(votes_total), 0);
    reset = 1'b0;
    tick(2);

    // Basic cast
    arm();
    hold(4'b0100, HOLD);
    check("basic_inc", 32'(vote_inc), 32'(4'b0100));
    check("basic_valid", 32'(valid_vote_casted), 1);
    check("basic_ready_low", 32'(ballot_ready), 0);
    model_vote(2);
    tick(1);
    check("basic_inc_end", 32'(vote_inc), 0);
    check("basic_valid_end", 32'(valid_vote_casted), 0);
    tick(LOCK + 2);
    scoreboard("basic");

    // Glitch reject, then a qualified press
    arm();
    hold(4'b0010, HOLD - 1);
    tick(1);
    check("glitch_rearmed", 32'(ballot_ready), 1);
    hold(4'b1000, HOLD);
    check("glitch_then_inc", 32'(vote_inc), 32'(4'b1000));
    model_vote(3);
    tick(LOCK + 3);
    scoreboard("glitch");

    // Multi-press
    arm();
    cand_button = 4'b0011;
    tick(1);
    cand_button = '0;
    exp_mp++;
    tick(1);
    check("multi_ready", 32'(ballot_ready), 1);
    check("multi_count", 32'(mp_seen), 32'(exp_mp));
    hold(4'b0001, HOLD);
    check("multi_then_inc", 32'(vote_inc), 32'(4'b0001));
    model_vote(0);
    tick(LOCK + 3);
    scoreboard("multi");

    // Lockout with held button and a stray arm pulse
    arm();
    cand_button = 4'b0100;
    tick(HOLD);
    check("lock_inc", 32'(vote_inc), 32'(4'b0100));
    model_vote(2);
    ready_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      ballot_enable = (i == 20);
      tick(1);
      ready_seen = ready_seen | ballot_ready;
    end
    ballot_enable = 1'b0;
    check("lock_no_rearm", 32'(ready_seen), 0);
    scoreboard("lock_held");
    cand_button   = '0;
    ballot_enable = 1'b1;
    tick(1);
    check("lock_release_idle", 32'(ballot_ready), 0);
    tick(1);
    check("lock_rearm", 32'(ballot_ready), 1);
    ballot_enable = 1'b0;
    hold(4'b0001, HOLD);
    model_vote(0);
    tick(LOCK + 3);
    check("lock_second_total", 32'(votes_total), 32'(exp_total));

    // Minimum lockout: vote, release at once, keep arm request high
    arm();
    hold(4'b0010, HOLD);
    check("minlock_inc", 32'(vote_inc), 32'(4'b0010));
    model_vote(1);
    ballot_enable = 1'b1;
    n = 0;
    while (!ballot_ready && n < 40) begin
      tick(1);
      n++;
    end
    ballot_enable = 1'b0;
    // one CAST cycle, LOCK lockout cycles, one IDLE cycle before ARMED shows
    check("minlock_cycles", 32'(n), 32'(LOCK + 2));
    mode = 1'b1;
    tick(1);
    mode = 1'b0;
    check("minlock_abort", 32'(ballot_ready), 0);
    scoreboard("minlock");

    // Timeout
    arm();
    tick(TO - 1);
    check("to_not_yet_ready", 32'(ballot_ready), 1);
    check("to_not_yet_pulse", 32'(timeout), 0);
    tick(1);
    check("to_pulse", 32'(timeout), 1);
    check("to_ready_low", 32'(ballot_ready), 0);
    exp_to++;
    tick(1);
    check("to_pulse_end", 32'(timeout), 0);

    // Mode abort mid-qualify and arm ignored in display mode
    arm();
    cand_button = 4'b1000;
    tick(2);
    mode = 1'b1;
    tick(1);
    check("mode_abort_ready", 32'(ballot_ready), 0);
    cand_button   = '0;
    ballot_enable = 1'b1;
    tick(2);
    check("mode_arm_ignored", 32'(ballot_ready), 0);
    ballot_enable = 1'b0;
    mode          = 1'b0;
    tick(HOLD + 2);
    scoreboard("mode");

    // Randomized sessions
    for (int s = 0; s < 25; s++) begin
      arm();
      k = $urandom_range(0, 2);
      for (int d = 0; d < k; d++) begin
        c = $urandom_range(0, NC - 1);
        if ($urandom_range(0, 1) == 1) begin
          hold(onehot(c), $urandom_range(1, HOLD - 1));
        end else begin
          pat = onehot(c) | onehot((c + 1 + $urandom_range(0, NC - 2)) % NC) |
                NC'($urandom_range(0, (1 << NC) - 1));
          cand_button = pat;
          tick(1);
          cand_button = '0;
          exp_mp++;
        end
        tick($urandom_range(1, 4));
        check("rand_still_armed", 32'(ballot_ready), 1);
      end
      c = $urandom_range(0, NC - 1);
      if ($urandom_range(0, 4) == 0) begin
        cand_button = onehot(c);
        tick($urandom_range(1, HOLD - 1));
        mode = 1'b1;
        tick(1);
        mode        = 1'b0;
        cand_button = '0;
        check("rand_abort_ready", 32'(ballot_ready), 0);
        tick(2);
      end else begin
        n = HOLD + $urandom_range(0, 5);
        cand_button = onehot(c);
        tick(HOLD);
        check("rand_inc", 32'(vote_inc), 32'(onehot(c)));
        tick(n - HOLD);
        cand_button = '0;
        model_vote(c);
        tick(LOCK + 2);
      end
      scoreboard("rand");
    end

    // Reset in the middle of qualification
    arm();
    cand_button = 4'b0010;
    tick(2);
    reset = 1'b1;
    tick(1);
    check("midrst_vote_inc", 32'(vote_inc), 0);
    check("midrst_valid", 32'(valid_vote_casted), 0);
    check("midrst_ready", 32'(ballot_ready), 0);
    check("midrst_multi", 32'(multi_press_err), 0);
    check("midrst_timeout", 32'(timeout), 0);
    check("midrst_total", 32'(votes_total), 0);
    reset     = 1'b0;
    exp_total = 0;
    tick(HOLD + 2);
    cand_button = '0;
    tick(2);
    scoreboard("midrst");

    // Saturation: preload the total just below full scale
    force dut.votes_total_q = 16'hFFFE;
    #1;
    release dut.votes_total_q;
    exp_total = 65534;
    tick(1);
    check("sat_preload", 32'(votes_total), 32'h0000FFFE);
    arm();
    hold(4'b0001, HOLD);
    check("sat_first_inc", 32'(vote_inc), 32'(4'b0001));
    model_vote(0);
    tick(LOCK + 2);
    check("sat_full", 32'(votes_total), 32'h0000FFFF);
    arm();
    hold(4'b0100, HOLD);
    check("sat_inc", 32'(vote_inc), 32'(4'b0100));
    check("sat_valid", 32'(valid_vote_casted), 1);
    model_vote(2);
    tick(LOCK + 2);
    scoreboard("sat");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
